// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by the RX deframer, the TX side and the RX FIFO.
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_deframer.sv
// Oversampled UART receiver: samples each bit at its centre, checks parity and stop
// bits, and holds one received word with its error flags on a valid/ready output.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RXC,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA_OUT,
   output logic                 DATA_VALID,
   input  logic                 DATA_READY,
   output logic                 PARITY_ERR,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN_ERR,
   output logic                 BUSY
);

   // Handshake: a word is transferred on any posedge where DATA_VALID && DATA_READY;
   // DATA_VALID, DATA_OUT and both flags stay stable until that transfer.

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
   // START is entered on the first low tick, so the centre is OVERSAMPLE/2-1 ticks
   // later; the compare sees the value before this tick's increment.
   localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 2);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
   localparam logic          ODD        = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

   rx_state_t               state;
   logic [TW-1:0]           tick_cnt;
   logic [BW-1:0]           bit_cnt;
   logic                    armed;
   logic [DATA_BITS-1:0]    shreg;
   logic                    par_flag;
   logic                    frm_flag;

   logic                    done;
   logic                    frm_final;
   logic                    accept;

   assign done      = RXC && (state == RX_STOP) && (tick_cnt == TICK_LAST) && (bit_cnt == STOP_LAST);
   assign frm_final = frm_flag | ~RXD;
   assign accept    = DATA_VALID && DATA_READY;
   assign BUSY      = (state != RX_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= RX_IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         armed       <= 1'b0;
         shreg       <= '0;
         par_flag    <= 1'b0;
         frm_flag    <= 1'b0;
         DATA_OUT    <= '0;
         DATA_VALID  <= 1'b0;
         PARITY_ERR  <= 1'b0;
         FRAME_ERR   <= 1'b0;
         OVERRUN_ERR <= 1'b0;
      end else begin
         OVERRUN_ERR <= 1'b0;

         if (RXC) begin
            case (state)
               RX_IDLE: begin
                  if (RXD) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state    <= RX_START;
                     tick_cnt <= '0;
                  end
               end
               RX_START: begin
                  if (tick_cnt == TICK_START) begin
                     tick_cnt <= '0;
                     if (RXD) begin
                        state <= RX_IDLE;
                        armed <= 1'b1;
                     end else begin
                        state    <= RX_DATA;
                        bit_cnt  <= '0;
                        par_flag <= 1'b0;
                        frm_flag <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               RX_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     shreg    <= {RXD, shreg[DATA_BITS-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               RX_PARITY: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     par_flag <= RXD ^ (^shreg) ^ ODD;
                     bit_cnt  <= '0;
                     state    <= RX_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               RX_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (!RXD) frm_flag <= 1'b1;
                     // Leaving at mid stop bit lets a back-to-back start edge be seen;
                     // a low stop bit leaves the receiver disarmed until the line idles.
                     if (bit_cnt == STOP_LAST) begin
                        state   <= RX_IDLE;
                        armed   <= RXD;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: begin
                  state    <= RX_IDLE;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
               end
            endcase
         end

         if (done) begin
            if (!DATA_VALID || DATA_READY) begin
               DATA_OUT   <= shreg;
               PARITY_ERR <= par_flag;
               FRAME_ERR  <= frm_final;
               DATA_VALID <= 1'b1;
            end else begin
               OVERRUN_ERR <= 1'b1;
            end
         end else if (accept) begin
            DATA_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: a default-framed instance and a parity/two-stop instance
// share one serial driver; accepted words are compared against frames built in the bench.
module tb_uart_rx_deframer;

   localparam int OS = 16;

   logic       clk;
   logic       rst;
   logic       rxc;
   logic       ser;
   logic       sel_par;
   logic       ready;
   logic       rxd;
   logic       rxd_p;

   logic [7:0] d_out,   d_out_p;
   logic       d_valid, d_valid_p;
   logic       p_err,   p_err_p;
   logic       f_err,   f_err_p;
   logic       o_err,   o_err_p;
   logic       busy,    busy_p;

   logic [7:0] m_data;
   logic       m_dv, m_pe, m_fe, m_ovr, m_busy;

   int         checks = 0;
   int         passed = 0;
   int         cyc = 0;
   int         rxc_div = 0;
   int         rise_cyc;
   int         stop_tick_cyc;
   int         ovr_cnt;
   int         ovr_cyc;
   logic       dv_q = 1'b0;

   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   assign rxd   = sel_par ? 1'b1 : ser;
   assign rxd_p = sel_par ? ser : 1'b1;

   assign m_data = sel_par ? d_out_p   : d_out;
   assign m_dv   = sel_par ? d_valid_p : d_valid;
   assign m_pe   = sel_par ? p_err_p   : p_err;
   assign m_fe   = sel_par ? f_err_p   : f_err;
   assign m_ovr  = sel_par ? o_err_p   : o_err;
   assign m_busy = sel_par ? busy_p    : busy;

   uart_rx_deframer dut (
      .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd),
      .DATA_OUT(d_out), .DATA_VALID(d_valid), .DATA_READY(ready),
      .PARITY_ERR(p_err), .FRAME_ERR(f_err), .OVERRUN_ERR(o_err), .BUSY(busy)
   );

   uart_rx_deframer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
      .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd_p),
      .DATA_OUT(d_out_p), .DATA_VALID(d_valid_p), .DATA_READY(ready),
      .PARITY_ERR(p_err_p), .FRAME_ERR(f_err_p), .OVERRUN_ERR(o_err_p), .BUSY(busy_p)
   );

   // clock / reset / tick generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rxc = 1'b0;
      forever begin
         @(negedge clk);
         rxc = (rxc_div == 3);
         rxc_div = (rxc_div + 1) % 4;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // observation: accepted words, valid rising edge, overrun pulses
   always @(negedge clk) begin
      if (m_dv && ready) got_q.push_back({m_fe, m_pe, m_data});
      if (m_ovr) begin
         ovr_cnt = ovr_cnt + 1;
         ovr_cyc = cyc;
      end
      if (m_dv && !dv_q) rise_cyc = cyc;
      dv_q = m_dv;
   end

   // driver tasks
   task automatic wait_tick();
      do @(posedge clk); while (rxc !== 1'b1);
      #1;
   endtask

   task automatic idle(input int n);
      ser = 1'b1;
      repeat (n) wait_tick();
   endtask

   // bits[0] is the start bit; stop_tick_cyc is the CLK cycle carrying the tick of the
   // last bit's centre sample
   task automatic send_frame(input logic [15:0] bits, input int nbits, input int nsend);
      for (int k = 0; k < nsend; k++) begin
         ser = bits[k];
         for (int j = 0; j < OS; j++) begin
            wait_tick();
            if (k == nbits - 1 && j == OS / 2 - 1) stop_tick_cyc = cyc - 1;
         end
      end
   endtask

   function automatic logic [15:0] frame_def(input logic [7:0] d, input logic stop);
      return {6'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_par(input logic [7:0] d, input logic pbit,
                                             input logic s1, input logic s2);
      return {4'b0, s2, s1, pbit, d, 1'b0};
   endfunction

   // tests
   task automatic test_reset();
      rst = 1'b1; ser = 1'b1; sel_par = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({d_out, d_valid, p_err, f_err, o_err, busy} !== 13'b0)
         $display("FAIL reset_outputs: got %h required 0", {d_out, d_valid, p_err, f_err, o_err, busy});
      else passed++;
      checks++;
      if ({d_out_p, d_valid_p, p_err_p, f_err_p, o_err_p, busy_p} !== 13'b0)
         $display("FAIL reset_outputs_par: got %h required 0", {d_out_p, d_valid_p, p_err_p, f_err_p, o_err_p, busy_p});
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(OS);
   endtask

   task automatic test_basic();
      logic [9:0] g;
      got_q.delete();
      rise_cyc = -1;
      send_frame(frame_def(8'hA5, 1'b1), 10, 10);
      idle(4);
      checks++;
      if (got_q.size() !== 1) $display("FAIL basic_count: got %0d required 1", got_q.size());
      else passed++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b00, 8'hA5}) $display("FAIL basic_word: got %h required %h", g, {2'b00, 8'hA5});
      else passed++;
      checks++;
      if (rise_cyc !== stop_tick_cyc + 1)
         $display("FAIL basic_latency: got cycle %0d required %0d", rise_cyc, stop_tick_cyc + 1);
      else passed++;
   endtask

   task automatic test_glitch();
      got_q.delete();
      ser = 1'b0;
      repeat (3) wait_tick();
      ser = 1'b1;
      repeat (4) wait_tick();
      checks++;
      if (m_busy !== 1'b1) $display("FAIL glitch_busy_before_centre: got %b required 1", m_busy);
      else passed++;
      wait_tick();
      checks++;
      if (m_busy !== 1'b0) $display("FAIL glitch_abort_at_centre: got %b required 0", m_busy);
      else passed++;
      idle(2 * OS);
      checks++;
      if (got_q.size() !== 0 || m_dv !== 1'b0)
         $display("FAIL glitch_no_word: got %0d words valid %b required 0 words valid 0", got_q.size(), m_dv);
      else passed++;
   endtask

   task automatic test_parity();
      logic [9:0] g;
      got_q.delete();
      sel_par = 1'b1;
      idle(OS);
      rise_cyc = -1;
      send_frame(frame_par(8'h03, 1'b1, 1'b1, 1'b1), 12, 12);
      idle(4);
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b01, 8'h03}) $display("FAIL parity_word: got %h required %h", g, {2'b01, 8'h03});
      else passed++;
      checks++;
      if (rise_cyc !== stop_tick_cyc + 1)
         $display("FAIL parity_latency: got cycle %0d required %0d", rise_cyc, stop_tick_cyc + 1);
      else passed++;
      sel_par = 1'b0;
      idle(OS);
   endtask

   task automatic test_frame_err();
      logic [9:0] g;
      logic any_busy;
      got_q.delete();
      send_frame(frame_def(8'h55, 1'b0), 10, 10);
      any_busy = 1'b0;
      ser = 1'b0;
      for (int i = 0; i < 40 * OS; i++) begin
         wait_tick();
         if (m_busy) any_busy = 1'b1;
      end
      checks++;
      if (any_busy !== 1'b0 || got_q.size() !== 1)
         $display("FAIL break_no_frame: got busy %b words %0d required busy 0 words 1", any_busy, got_q.size());
      else passed++;
      idle(OS);
      send_frame(frame_def(8'h3C, 1'b1), 10, 10);
      idle(4);
      checks++;
      if (got_q.size() !== 2) $display("FAIL frame_count: got %0d required 2", got_q.size());
      else passed++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b10, 8'h55}) $display("FAIL frame_err_word: got %h required %h", g, {2'b10, 8'h55});
      else passed++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b00, 8'h3C}) $display("FAIL frame_recover_word: got %h required %h", g, {2'b00, 8'h3C});
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [9:0] g;
      got_q.delete();
      ready = 1'b0;
      ovr_cnt = 0;
      ovr_cyc = -1;
      send_frame(frame_def(8'h11, 1'b1), 10, 10);
      send_frame(frame_def(8'h22, 1'b1), 10, 10);
      idle(4);
      checks++;
      if (m_dv !== 1'b1 || m_data !== 8'h11)
         $display("FAIL overrun_held: got valid %b data %h required valid 1 data 11", m_dv, m_data);
      else passed++;
      checks++;
      if (ovr_cnt !== 1) $display("FAIL overrun_pulse_width: got %0d cycles required 1", ovr_cnt);
      else passed++;
      checks++;
      if (ovr_cyc !== stop_tick_cyc + 1)
         $display("FAIL overrun_timing: got cycle %0d required %0d", ovr_cyc, stop_tick_cyc + 1);
      else passed++;
      ready = 1'b1;
      idle(4);
      checks++;
      if (got_q.size() !== 1) $display("FAIL overrun_drain_count: got %0d required 1", got_q.size());
      else passed++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b00, 8'h11}) $display("FAIL overrun_drain_word: got %h required %h", g, {2'b00, 8'h11});
      else passed++;
      checks++;
      if (m_dv !== 1'b0) $display("FAIL overrun_valid_clear: got %b required 0", m_dv);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [9:0] g;
      got_q.delete();
      send_frame(frame_def(8'h7E, 1'b1), 10, 4);
      ser = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({d_out, d_valid, p_err, f_err, o_err, busy} !== 13'b0)
         $display("FAIL reset_mid_outputs: got %h required 0", {d_out, d_valid, p_err, f_err, o_err, busy});
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2 * OS);
      send_frame(frame_def(8'h81, 1'b1), 10, 10);
      idle(4);
      checks++;
      if (got_q.size() !== 1) $display("FAIL reset_mid_count: got %0d required 1", got_q.size());
      else passed++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== {2'b00, 8'h81}) $display("FAIL reset_mid_word: got %h required %h", g, {2'b00, 8'h81});
      else passed++;
   endtask

   // random frames on both instances; expected flags come straight from the frame content
   task automatic test_random();
      logic [7:0] d;
      logic       pbit, s1, s2, stop, low_end, use_par;
      logic [9:0] e, g;
      ready = 1'b1;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < 24; i++) begin
         use_par = ($urandom_range(0, 1) == 1);
         if (use_par != sel_par) begin
            sel_par = use_par;
            idle(OS);
         end
         d = 8'($urandom_range(0, 255));
         if (use_par) begin
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            exp_q.push_back({~(s1 & s2), (pbit != (^d)), d});
            send_frame(frame_par(d, pbit, s1, s2), 12, 12);
            low_end = ~s2;
         end else begin
            stop = ($urandom_range(0, 4) != 0);
            exp_q.push_back({~stop, 1'b0, d});
            send_frame(frame_def(d, stop), 10, 10);
            low_end = ~stop;
         end
         idle($urandom_range(low_end ? 1 : 0, 12));
      end
      idle(8);
      checks++;
      if (got_q.size() !== exp_q.size())
         $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size());
      else passed++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
         checks++;
         if (g !== e) $display("FAIL random_word: got %h required %h", g, e);
         else passed++;
      end
      sel_par = 1'b0;
   endtask

   initial begin
      ovr_cnt = 0;
      ovr_cyc = -1;
      rise_cyc = -1;
      stop_tick_cyc = 0;
      test_reset();
      test_basic();
      test_glitch();
      test_parity();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
